frame_recv_multi: RTL and testbench

FRAME_RECV_MULTI -- requirements
Module: frame_recv_multi

---
 rtl/frame_recv_multi.sv | 241 ++++++++++++++++++++++++
 tb/tb_frame_recv_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_recv_multi.sv
// Framed octet receiver: preamble/SFD sync, multi-entry destination MAC filter, length, payload FIFO, LRC check.
// Optional macro FRAME_RECV_BROADCAST_EN also accepts the FF:FF:FF:FF:FF:FF destination (reported as mac_idx 7).
module frame_recv_multi #(
  parameter int NUM_MAC = 2,
  parameter logic [NUM_MAC*48-1:0] MAC_TABLE = {48'h00_0a_95_9d_68_17, 48'h00_0a_95_9d_68_16},
  parameter int PREAMBLE_LEN = 7,
  parameter int MAX_PAYLOAD = 1500,
  parameter int FIFO_DEPTH = 16,
  parameter int FCS_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       in_vld,
  output logic       rdy,
  output logic [7:0] out_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [3:0] err_code,
  output logic [2:0] mac_idx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] FCS_LAST = 16'(FCS_LEN - 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, MACDST, MACSRC, LEN, PAYLOAD, FCS, DONE, ERROR
  } state_t;

  state_t state, state_n;
  logic [15:0] cnt, cnt_n, len, len_n;
  logic [7:0] lrc, lrc_n, lrc_add;
  logic [NUM_MAC-1:0] match, match_n, oct_match, hit;
  logic [3:0] err, err_n;
  logic [2:0] idx, idx_n, hit_idx, dst_byte;
  logic bcast_hit;
  logic push, push_last, pop, empty, full;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [8:0] mem [FIFO_DEPTH];
  logic [8:0] rd_word;

`ifdef FRAME_RECV_BROADCAST_EN
  logic bcast, bcast_n;
  assign bcast_hit = bcast && (data == 8'hFF);
`else
  assign bcast_hit = 1'b0;
`endif

  assign lrc_add = lrc + data;
  assign dst_byte = (cnt[2:0] > 3'd5) ? 3'd0 : 3'd5 - cnt[2:0];

  // Each table entry is compared one octet at a time, first wire octet in bits [47:40].
  always_comb begin
    oct_match = '0;
    for (int i = 0; i < NUM_MAC; i++)
      oct_match[i] = (MAC_TABLE[48*i + 8*dst_byte +: 8] == data);
  end

  always_comb begin
    hit = match & oct_match;
    hit_idx = 3'd0;
    for (int i = NUM_MAC - 1; i >= 0; i--)
      if (hit[i]) hit_idx = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      lrc <= '0;
      match <= '0;
      err <= '0;
      idx <= '0;
`ifdef FRAME_RECV_BROADCAST_EN
      bcast <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      len <= len_n;
      lrc <= lrc_n;
      match <= match_n;
      err <= err_n;
      idx <= idx_n;
`ifdef FRAME_RECV_BROADCAST_EN
      bcast <= bcast_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    len_n = len;
    lrc_n = lrc;
    match_n = match;
    err_n = err;
    idx_n = idx;
    push = 1'b0;
    push_last = 1'b0;
`ifdef FRAME_RECV_BROADCAST_EN
    bcast_n = bcast;
`endif
    case (state)
      IDLE:
        if (start) begin
          state_n = PREAMBLE;
          cnt_n = '0;
          len_n = '0;
          lrc_n = '0;
        end
      PREAMBLE:
        if (in_vld) begin
          if (data != 8'hAA) begin
            state_n = ERROR;
            err_n = 4'd1;
          end else if (cnt == PRE_LAST) begin
            state_n = SFD;
            cnt_n = '0;
          end else cnt_n = cnt + 16'd1;
        end
      SFD:
        if (in_vld) begin
          if (data != 8'hAB) begin
            state_n = ERROR;
            err_n = 4'd2;
          end else begin
            state_n = MACDST;
            cnt_n = '0;
            match_n = '1;
`ifdef FRAME_RECV_BROADCAST_EN
            bcast_n = 1'b1;
`endif
          end
        end
      MACDST:
        if (in_vld) begin
          lrc_n = lrc_add;
          match_n = hit;
`ifdef FRAME_RECV_BROADCAST_EN
          bcast_n = bcast_hit;
`endif
          if (cnt == 16'd5) begin
            cnt_n = '0;
            // Table hits win over broadcast; a total miss drops the frame silently.
            if (|hit) begin
              state_n = MACSRC;
              idx_n = hit_idx;
            end else if (bcast_hit) begin
              state_n = MACSRC;
              idx_n = 3'd7;
            end else state_n = IDLE;
          end else cnt_n = cnt + 16'd1;
        end
      MACSRC:
        if (in_vld) begin
          lrc_n = lrc_add;
          if (cnt == 16'd5) begin
            state_n = LEN;
            cnt_n = '0;
          end else cnt_n = cnt + 16'd1;
        end
      LEN:
        if (in_vld) begin
          lrc_n = lrc_add;
          len_n = {len[7:0], data};
          if (cnt == 16'd1) begin
            cnt_n = '0;
            if (len_n > MAX_LEN) begin
              state_n = ERROR;
              err_n = 4'd3;
            end else if (len_n == 16'd0) state_n = FCS;
            else state_n = PAYLOAD;
          end else cnt_n = cnt + 16'd1;
        end
      PAYLOAD:
        if (in_vld) begin
          if (full && !pop) begin
            state_n = ERROR;
            err_n = 4'd5;
          end else begin
            push = 1'b1;
            push_last = (cnt == len - 16'd1);
            lrc_n = lrc_add;
            if (push_last) begin
              state_n = FCS;
              cnt_n = '0;
            end else cnt_n = cnt + 16'd1;
          end
        end
      FCS:
        if (in_vld) begin
          if (data != (~lrc + 8'd1)) begin
            state_n = ERROR;
            err_n = 4'd4;
          end else if (cnt == FCS_LAST) state_n = DONE;
          else cnt_n = cnt + 16'd1;
        end
      DONE: state_n = IDLE;
      ERROR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FWFT buffer: drains on its own regardless of where the FSM is.
  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = !empty && out_rdy;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {push_last, data};
  end

  assign rdy = (state == IDLE);
  assign out_vld = !empty;
  assign out_data = empty ? 8'h00 : rd_word[7:0];
  assign out_last = empty ? 1'b0 : rd_word[8];
  assign frame_ok = (state == DONE);
  assign frame_err = (state == ERROR);
  assign err_code = frame_err ? err : 4'd0;
  assign mac_idx = frame_ok ? idx : 3'd0;

endmodule

// File: tb/tb_frame_recv_multi.sv
// Scoreboard bench for frame_recv_multi: a default instance plus a FIFO_DEPTH=4 instance for overflow.
module tb_frame_recv_multi;

  localparam int PRE_LEN = 7;
  localparam logic [47:0] MAC0 = 48'h00_0a_95_9d_68_16;
  localparam logic [47:0] MAC1 = 48'h00_0a_95_9d_68_17;
  localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;

  typedef struct packed {
    logic ok;
    logic [3:0] code;
    logic [2:0] idx;
  } evt_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_vld = 1'b0;
  logic [7:0] data = 8'h00;
  logic rdy, out_vld, out_last, frame_ok, frame_err, out_rdy = 1'b1;
  logic [7:0] out_data;
  logic [3:0] err_code;
  logic [2:0] mac_idx;
  logic s_rdy, s_out_vld, s_out_last, s_frame_ok, s_frame_err, s_out_rdy = 1'b1;
  logic [7:0] s_out_data;
  logic [3:0] s_err_code;
  logic [2:0] s_mac_idx;

  int errors = 0;
  int checks = 0;
  bit check_small = 1'b0;
  logic [8:0] exp_out[$];
  logic [8:0] s_exp_out[$];
  evt_t exp_evt[$];
  evt_t s_exp_evt[$];
  logic [7:0] frame_q[$];

  frame_recv_multi dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .in_vld(in_vld), .rdy(rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .mac_idx(mac_idx)
  );

  frame_recv_multi #(.FIFO_DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start), .data(data), .in_vld(in_vld), .rdy(s_rdy),
    .out_data(s_out_data), .out_vld(s_out_vld), .out_rdy(s_out_rdy), .out_last(s_out_last),
    .frame_ok(s_frame_ok), .frame_err(s_frame_err), .err_code(s_err_code), .mac_idx(s_mac_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got=%0h required=nothing", name, actual);
  endtask

  // Monitor for the default instance; active in every test.
  always @(negedge clk) begin
    evt_t e;
    logic [8:0] o;
    if (!rst) begin
      if (out_vld && out_rdy) begin
        if (exp_out.size() == 0) unexpected("out_unexpected", {23'd0, out_last, out_data});
        else begin
          o = exp_out.pop_front();
          checkOutput("out_word", {23'd0, out_last, out_data}, {23'd0, o});
        end
      end
      if (frame_ok || frame_err) begin
        if (exp_evt.size() == 0) unexpected("evt_unexpected", {30'd0, frame_ok, frame_err});
        else begin
          e = exp_evt.pop_front();
          checkOutput("frame_ok", {31'd0, frame_ok}, {31'd0, e.ok});
          if (e.ok) checkOutput("mac_idx", {29'd0, mac_idx}, {29'd0, e.idx});
          else checkOutput("err_code", {28'd0, err_code}, {28'd0, e.code});
        end
      end
    end
  end

  // Monitor for the small-FIFO instance; only armed for the overflow test.
  always @(negedge clk) begin
    evt_t e;
    logic [8:0] o;
    if (!rst && check_small) begin
      if (s_out_vld && s_out_rdy) begin
        if (s_exp_out.size() == 0) unexpected("s_out_unexpected", {23'd0, s_out_last, s_out_data});
        else begin
          o = s_exp_out.pop_front();
          checkOutput("s_out_word", {23'd0, s_out_last, s_out_data}, {23'd0, o});
        end
      end
      if (s_frame_ok || s_frame_err) begin
        if (s_exp_evt.size() == 0) unexpected("s_evt_unexpected", {30'd0, s_frame_ok, s_frame_err});
        else begin
          e = s_exp_evt.pop_front();
          checkOutput("s_frame_ok", {31'd0, s_frame_ok}, {31'd0, e.ok});
          checkOutput("s_err_code", {28'd0, s_err_code}, {28'd0, e.code});
        end
      end
    end
  end

  function automatic evt_t mk_evt(input logic ok, input logic [3:0] code, input logic [2:0] idx);
    evt_t e;
    e.ok = ok;
    e.code = code;
    e.idx = idx;
    return e;
  endfunction

  // Payload is npay consecutive octets starting at pay0; FCS is four copies of (~LRC + 1).
  task automatic build_frame(input logic [47:0] dst, input logic [15:0] len, input int npay, input logic [7:0] pay0);
    logic [7:0] sum, b;
    frame_q.delete();
    sum = 8'h00;
    for (int i = 0; i < PRE_LEN; i++) frame_q.push_back(8'hAA);
    frame_q.push_back(8'hAB);
    for (int i = 5; i >= 0; i--) begin b = dst[8*i +: 8]; frame_q.push_back(b); sum += b; end
    for (int i = 5; i >= 0; i--) begin b = SRC[8*i +: 8]; frame_q.push_back(b); sum += b; end
    frame_q.push_back(len[15:8]); sum += len[15:8];
    frame_q.push_back(len[7:0]); sum += len[7:0];
    for (int i = 0; i < npay; i++) begin b = pay0 + 8'(i); frame_q.push_back(b); sum += b; end
    for (int i = 0; i < 4; i++) frame_q.push_back(~sum + 8'd1);
  endtask

  task automatic applyStimulus(input bit toggle, input int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      data = frame_q[i];
      in_vld = 1'b1;
      @(posedge clk); #1;
      if (toggle) begin
        in_vld = 1'b0;
        data = 8'h00;
        @(posedge clk); #1;
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int left;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      left = exp_out.size() + exp_evt.size() + s_exp_evt.size() + (s_out_rdy ? s_exp_out.size() : 0);
      if (left == 0) break;
      @(posedge clk);
    end
    #1;
    left = exp_out.size() + exp_evt.size() + s_exp_evt.size() + (s_out_rdy ? s_exp_out.size() : 0);
    checkOutput({"drain_", name}, left, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_out.delete();
    exp_evt.delete();
    s_exp_out.delete();
    s_exp_evt.delete();
  endtask

  initial begin
    do_reset();
    checkOutput("rst_rdy", {31'd0, rdy}, 1);
    checkOutput("rst_out_vld", {31'd0, out_vld}, 0);
    checkOutput("rst_out_last", {31'd0, out_last}, 0);
    checkOutput("rst_out_data", {24'd0, out_data}, 0);
    checkOutput("rst_frame_ok", {31'd0, frame_ok}, 0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 0);
    checkOutput("rst_err_code", {28'd0, err_code}, 0);
    checkOutput("rst_mac_idx", {29'd0, mac_idx}, 0);

    // Entry 0, payload 01 02 03: LRC = 8'hC6, FCS octets 8'h3A.
    build_frame(MAC0, 16'd3, 3, 8'h01);
    checkOutput("fcs_a", {24'd0, frame_q[frame_q.size()-1]}, 32'h3A);
    exp_out.push_back(9'h001); exp_out.push_back(9'h002); exp_out.push_back(9'h103);
    exp_evt.push_back(mk_evt(1'b1, 4'd0, 3'd0));
    applyStimulus(1'b0, frame_q.size());
    wait_drain("entry0");

    // Entry 1 with stalls between every octet.
    build_frame(MAC1, 16'd3, 3, 8'h01);
    exp_out.push_back(9'h001); exp_out.push_back(9'h002); exp_out.push_back(9'h103);
    exp_evt.push_back(mk_evt(1'b1, 4'd0, 3'd1));
    applyStimulus(1'b1, frame_q.size());
    wait_drain("entry1_stall");

    build_frame(MAC0, 16'd3, 3, 8'h01);
    frame_q[2] = 8'h55;
    exp_evt.push_back(mk_evt(1'b0, 4'd1, 3'd0));
    applyStimulus(1'b0, frame_q.size());
    wait_drain("preamble_err");
    checkOutput("preamble_fifo_empty", {31'd0, out_vld}, 0);

    build_frame(MAC0, 16'h0600, 0, 8'h00);
    exp_evt.push_back(mk_evt(1'b0, 4'd3, 3'd0));
    applyStimulus(1'b0, frame_q.size());
    wait_drain("len_too_big");

    build_frame(MAC0, 16'd0, 0, 8'h00);
    exp_evt.push_back(mk_evt(1'b1, 4'd0, 3'd0));
    applyStimulus(1'b0, frame_q.size());
    wait_drain("len_zero");

    // Only the last FCS octet is wrong.
    build_frame(MAC0, 16'd1, 1, 8'h20);
    frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'h01;
    exp_out.push_back(9'h120);
    exp_evt.push_back(mk_evt(1'b0, 4'd4, 3'd0));
    applyStimulus(1'b0, frame_q.size());
    wait_drain("fcs_err");

    build_frame(48'h11_22_33_44_55_66, 16'd3, 3, 8'h01);
    applyStimulus(1'b0, 14);
    checkOutput("unknown_dst_idle", {31'd0, rdy}, 1);
    applyStimulus(1'b0, frame_q.size());
    wait_drain("unknown_dst");

    build_frame(48'hFF_FF_FF_FF_FF_FF, 16'd2, 2, 8'h30);
`ifdef FRAME_RECV_BROADCAST_EN
    exp_out.push_back(9'h030); exp_out.push_back(9'h131);
    exp_evt.push_back(mk_evt(1'b1, 4'd0, 3'd7));
`endif
    applyStimulus(1'b0, frame_q.size());
    wait_drain("broadcast");

    // Overflow on the 4-deep instance while the default instance completes normally.
    do_reset();
    check_small = 1'b1;
    s_out_rdy = 1'b0;
    build_frame(MAC0, 16'd6, 6, 8'h10);
    for (int i = 0; i < 6; i++) exp_out.push_back({(i == 5), 8'h10 + 8'(i)});
    exp_evt.push_back(mk_evt(1'b1, 4'd0, 3'd0));
    for (int i = 0; i < 4; i++) s_exp_out.push_back({1'b0, 8'h10 + 8'(i)});
    s_exp_evt.push_back(mk_evt(1'b0, 4'd5, 3'd0));
    applyStimulus(1'b0, frame_q.size());
    wait_drain("overflow");
    checkOutput("overflow_hold_vld", {31'd0, s_out_vld}, 1);
    checkOutput("overflow_hold_data", {24'd0, s_out_data}, 32'h10);
    s_out_rdy = 1'b1;
    wait_drain("overflow_drain");
    checkOutput("overflow_empty", {31'd0, s_out_vld}, 0);
    check_small = 1'b0;

    // Reset after two payload octets are buffered.
    do_reset();
    out_rdy = 1'b0;
    build_frame(MAC0, 16'd3, 3, 8'h01);
    applyStimulus(1'b0, 24);
    checkOutput("mid_buffered", {31'd0, out_vld}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_rst_rdy", {31'd0, rdy}, 1);
    checkOutput("mid_rst_out_vld", {31'd0, out_vld}, 0);
    out_rdy = 1'b1;
    wait_drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
